// File: rtl/my_mem_pkg.sv
// Shared types and helpers for the parity-protected memory family.
package my_mem_pkg;

  localparam int unsigned MAX_DATA_W = 64;

  // Widest stored word supported; narrower instances zero-extend into it.
  typedef logic [MAX_DATA_W:0] mem_word_t;

  typedef struct packed {
    logic par_err;
    logic unwr;
    logic addr_err;
  } rd_status_t;

  function automatic logic parity(input mem_word_t data);
    return ^data;
  endfunction

endpackage

// File: rtl/my_mem_err_cnt.sv
// Saturating fault counter; a clear coinciding with an increment leaves one count.
module my_mem_err_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/my_mem_par.sv
// Parity-protected single-port synchronous memory with read status flags
// and a saturating fault counter.
module my_mem_par
  import my_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              inj_err,
  input  logic              err_clr,
  output logic [DATA_W:0]   data_out,
  output logic              rd_valid,
  output logic              par_err,
  output logic              unwr,
  output logic              addr_err,
  output logic [CNT_W-1:0]  error_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]  wv_q, wv_d;
  logic [DATA_W:0]   data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  rd_status_t        status_q, status_d;

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W:0]   rd_word;
  logic [DATA_W:0]   wr_word;
  logic              mem_we;
  logic              rd_par_fault;
  logic              cnt_inc;

  assign in_range = {1'b0, address} < DEPTH_L;
  assign idx      = address[IDX_W-1:0];
  assign rd_word  = mem_q[idx];
  assign wr_word  = {parity(mem_word_t'(data_in)) ^ inj_err, data_in};
  assign mem_we   = write && in_range && !rst;

  // Flags use the pre-edge word and wv, giving read-before-write on collision.
  assign rd_par_fault = read && in_range && wv_q[idx] && parity(mem_word_t'(rd_word));

  always_comb begin
    wv_d       = wv_q;
    data_out_d = data_out_q;
    rd_valid_d = read;
    status_d   = status_q;
    cnt_inc    = 1'b0;

    if (write && in_range) wv_d[idx] = 1'b1;

    if (read) begin
      status_d.par_err = 1'b0;
      status_d.unwr    = 1'b0;
      data_out_d       = '0;
      if (in_range) begin
        if (wv_q[idx]) begin
          data_out_d       = rd_word;
          status_d.par_err = rd_par_fault;
        end else begin
          status_d.unwr = 1'b1;
        end
      end
    end

    // One addr_err pulse per faulting cycle, even if read and write both fault.
    status_d.addr_err = (read || write) && !in_range;
    cnt_inc           = status_d.addr_err || rd_par_fault;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wv_q       <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      status_q   <= '0;
    end else begin
      wv_q       <= wv_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      status_q   <= status_d;
    end
  end

  my_mem_err_cnt #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .clr  (err_clr),
    .count(error_count)
  );

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign par_err  = status_q.par_err;
  assign unwr     = status_q.unwr;
  assign addr_err = status_q.addr_err;

endmodule

// File: tb/tb_my_mem_par.sv
// Directed bench for my_mem_par: default instance plus a CNT_W=2 instance
// sharing stimulus to exercise counter saturation.
module tb_my_mem_par;

  logic        clk = 1'b0;
  logic        rst;
  logic        write, read, inj_err, err_clr;
  logic [15:0] address;
  logic [7:0]  data_in;

  logic [8:0]  data_out, data_out2;
  logic        rd_valid, par_err, unwr, addr_err;
  logic        rd_valid2, par_err2, unwr2, addr_err2;
  logic [7:0]  error_count;
  logic [1:0]  error_count2;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  my_mem_par #(.DATA_W(8), .ADDR_W(16), .DEPTH(256), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .write(write), .read(read), .address(address),
    .data_in(data_in), .inj_err(inj_err), .err_clr(err_clr),
    .data_out(data_out), .rd_valid(rd_valid), .par_err(par_err), .unwr(unwr),
    .addr_err(addr_err), .error_count(error_count)
  );

  my_mem_par #(.DATA_W(8), .ADDR_W(16), .DEPTH(256), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .write(write), .read(read), .address(address),
    .data_in(data_in), .inj_err(inj_err), .err_clr(err_clr),
    .data_out(data_out2), .rd_valid(rd_valid2), .par_err(par_err2), .unwr(unwr2),
    .addr_err(addr_err2), .error_count(error_count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 1'b0; read = 1'b0; inj_err = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    address = '0;
    data_in = '0;
    cycle();
    cycle();
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    chk("rst_count",    32'(error_count), 32'h0);
    rst = 1'b0;

    // Unwritten location
    read = 1'b1; address = 16'h0005;
    cycle();
    chk("unwr_rd_valid", 32'(rd_valid), 32'h1);
    chk("unwr_flag",     32'(unwr), 32'h1);
    chk("unwr_data",     32'(data_out), 32'h000);
    chk("unwr_count",    32'(error_count), 32'h0);
    idle();

    // Two writes, then back-to-back reads
    write = 1'b1; address = 16'h0010; data_in = 8'hA3;
    cycle();
    address = 16'h0011; data_in = 8'h07;
    cycle();
    idle();
    read = 1'b1; address = 16'h0010;
    cycle();
    chk("rd10_data", 32'(data_out), 32'h0A3);
    chk("rd10_par",  32'(par_err), 32'h0);
    address = 16'h0011;
    cycle();
    chk("rd11_data",  32'(data_out), 32'h107);
    chk("rd11_par",   32'(par_err), 32'h0);
    chk("rd11_unwr",  32'(unwr), 32'h0);
    chk("rd11_valid", 32'(rd_valid), 32'h1);
    idle();
    cycle();
    chk("idle_valid", 32'(rd_valid), 32'h0);
    chk("idle_hold",  32'(data_out), 32'h107);

    // Injected parity fault
    write = 1'b1; inj_err = 1'b1; address = 16'h0020; data_in = 8'h55;
    cycle();
    idle();
    read = 1'b1;
    cycle();
    chk("inj_data",  32'(data_out), 32'h155);
    chk("inj_par",   32'(par_err), 32'h1);
    chk("inj_count", 32'(error_count), 32'h1);
    idle();

    // Out-of-range write then read
    write = 1'b1; address = 16'h0100; data_in = 8'h11;
    cycle();
    chk("oorw_addr_err", 32'(addr_err), 32'h1);
    chk("oorw_count",    32'(error_count), 32'h2);
    idle();
    read = 1'b1;
    cycle();
    chk("oorr_addr_err", 32'(addr_err), 32'h1);
    chk("oorr_data",     32'(data_out), 32'h000);
    chk("oorr_count",    32'(error_count), 32'h3);
    address = 16'h0000;
    cycle();
    chk("alias0_unwr",     32'(unwr), 32'h1);
    chk("alias0_addr_err", 32'(addr_err), 32'h0);
    idle();
    write = 1'b1; read = 1'b1; address = 16'hFFFF;
    cycle();
    chk("oorrw_addr_err", 32'(addr_err), 32'h1);
    chk("oorrw_count",    32'(error_count), 32'h4);
    idle();
    cycle();
    chk("idle_addr_err", 32'(addr_err), 32'h0);

    // Read-before-write collision
    write = 1'b1; read = 1'b1; address = 16'h0010; data_in = 8'hFF;
    cycle();
    chk("rbw_old", 32'(data_out), 32'h0A3);
    write = 1'b0;
    cycle();
    chk("rbw_new",   32'(data_out), 32'h0FF);
    chk("rbw_count", 32'(error_count), 32'h4);
    idle();

    // Saturation on CNT_W=2, clear with coincident fault
    err_clr = 1'b1;
    cycle();
    chk("clr_count",  32'(error_count), 32'h0);
    chk("clr_count2", 32'(error_count2), 32'h0);
    err_clr = 1'b0;
    read = 1'b1; address = 16'h0020;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk($sformatf("sat2_%0d", i), 32'(error_count2), (i > 3) ? 32'd3 : 32'(i));
      chk($sformatf("sat8_%0d", i), 32'(error_count), 32'(i));
    end
    err_clr = 1'b1;
    cycle();
    chk("clrinc_count",  32'(error_count), 32'h1);
    chk("clrinc_count2", 32'(error_count2), 32'h1);
    err_clr = 1'b0;

    // Asynchronous reset mid-read
    address = 16'h0010;
    cycle();
    chk("pre_rst_data", 32'(data_out), 32'h0FF);
    rst = 1'b1;
    #1;
    chk("arst_data",     32'(data_out), 32'h0);
    chk("arst_valid",    32'(rd_valid), 32'h0);
    chk("arst_par",      32'(par_err), 32'h0);
    chk("arst_unwr",     32'(unwr), 32'h0);
    chk("arst_addr_err", 32'(addr_err), 32'h0);
    chk("arst_count",    32'(error_count), 32'h0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("post_rst_unwr", 32'(unwr), 32'h1);
    chk("post_rst_data", 32'(data_out), 32'h000);
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
